// File: rtl/xbar_pkg.sv
// Shared types and helpers for xbar slave-side adapters.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package xbar_pkg;

    localparam int XBAR_DATA_W = 32;
    localparam int XBAR_ADDR_W = 32;

    // One slot of a read-response pipeline.
    typedef struct packed {
        logic                   valid;
        logic [XBAR_DATA_W-1:0] data;
    } rd_entry_t;

    // Byte address to word index, keeping only the low idx_w index bits so
    // addresses beyond the RAM depth alias back into it.
    function automatic logic [XBAR_ADDR_W-1:0] word_idx(
        input logic [XBAR_ADDR_W-1:0] addr,
        input int                     idx_w
    );
        logic [XBAR_ADDR_W-1:0] mask;
        mask = (XBAR_ADDR_W'(1) << idx_w) - XBAR_ADDR_W'(1);
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/xbar_slave_resp_pipe.sv
// Valid/data shift register that delays read data to a fixed response time.
// Latency: LATENCY cycles from in_vld to out_vld.
// Backpressure: none; one entry enters and one leaves every cycle.
module xbar_slave_resp_pipe
    import xbar_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_vld,
    input  logic [XBAR_DATA_W-1:0] in_dat,
    output logic                   out_vld,
    output logic [XBAR_DATA_W-1:0] out_dat
);

    rd_entry_t stage_q [LATENCY];

    // Shift entries one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: in_vld, data: in_dat};
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_vld = stage_q[LATENCY-1].valid;
    assign out_dat = stage_q[LATENCY-1].data;

endmodule

// File: rtl/xbar_slave_ram.sv
// Word-addressed RAM responder for an xbar slave port, with background init fill.
// Latency: writes take effect at the accept edge; reads respond READ_LATENCY cycles after ack.
// Backpressure: ack_o drops on stall_i, during init fill, or when MAX_OUTSTANDING reads are pending.
module xbar_slave_ram
    import xbar_pkg::*;
#(
    parameter int                     MEMSIZE32       = 1024,
    parameter int                     READ_LATENCY    = 2,
    parameter int                     MAX_OUTSTANDING = 4,
    parameter logic [XBAR_DATA_W-1:0] INIT_BASE       = 32'h0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   init_i,
    output logic                   init_busy_o,
    input  logic                   stall_i,
    input  logic                   req_i,
    output logic                   ack_o,
    input  logic [XBAR_ADDR_W-1:0] addr_bi,
    input  logic                   we_i,
    input  logic [XBAR_DATA_W-1:0] wdata_bi,
    output logic                   resp_o,
    output logic [XBAR_DATA_W-1:0] rdata_bo
);

    localparam int IDX_W = $clog2(MEMSIZE32);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [0:0] {
        INIT_IDLE = 1'b0,
        INIT_FILL = 1'b1
    } init_state_t;

    logic [XBAR_DATA_W-1:0] mem [MEMSIZE32];

    init_state_t            init_state_q;
    init_state_t            init_state_d;
    logic [IDX_W-1:0]       init_idx_q;
    logic [IDX_W-1:0]       init_idx_d;

    logic [XBAR_ADDR_W-1:0] word_sel;
    logic [IDX_W-1:0]       idx;
    logic                   unused_idx_hi;

    logic [CNT_W-1:0]       outstanding_q;
    logic                   rd_ok;
    logic                   rd_acc;

    logic                   resp_vld;
    logic [XBAR_DATA_W-1:0] resp_dat;

    logic                   mem_we;
    logic [IDX_W-1:0]       mem_widx;
    logic [XBAR_DATA_W-1:0] mem_wdat;

    assign word_sel      = word_idx(addr_bi, IDX_W);
    assign idx           = word_sel[IDX_W-1:0];
    assign unused_idx_hi = |word_sel[XBAR_ADDR_W-1:IDX_W];

    assign init_busy_o = (init_state_q == INIT_FILL);

    // A response leaving this cycle frees a slot, so a full counter can
    // still accept and back-to-back reads keep flowing.
    assign rd_ok  = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) | resp_vld;
    assign ack_o  = req_i & ~stall_i & ~init_busy_o & ~rst_i & (we_i | rd_ok);
    assign rd_acc = ack_o & ~we_i;

    // Init fill state and index register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_state_q <= INIT_IDLE;
            init_idx_q   <= '0;
        end else begin
            init_state_q <= init_state_d;
            init_idx_q   <= init_idx_d;
        end
    end

    // Init fill sequencing: one word per cycle, index 0 up to the last word.
    always_comb begin
        init_state_d = init_state_q;
        init_idx_d   = init_idx_q;
        case (init_state_q)
            INIT_IDLE: begin
                if (init_i) begin
                    init_state_d = INIT_FILL;
                    init_idx_d   = '0;
                end
            end
            INIT_FILL: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_W'(MEMSIZE32 - 1)) begin
                    init_state_d = INIT_IDLE;
                end
            end
            default: init_state_d = INIT_IDLE;
        endcase
    end

    // Single RAM write port shared by the init fill and host writes; host
    // writes are never acked while the fill runs, so they cannot collide.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = idx;
        mem_wdat = wdata_bi;
        if (init_busy_o && !rst_i) begin
            mem_we   = 1'b1;
            mem_widx = init_idx_q;
            mem_wdat = INIT_BASE + (XBAR_DATA_W'(init_idx_q) << 2);
        end else if (ack_o && we_i) begin
            mem_we   = 1'b1;
        end
    end

    // RAM storage; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // Count reads accepted but not yet answered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_acc, resp_vld})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Read data is captured at the accept edge, so a write on the next
    // cycle cannot disturb a read already in flight.
    xbar_slave_resp_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (rd_acc),
        .in_dat  (mem[idx]),
        .out_vld (resp_vld),
        .out_dat (resp_dat)
    );

    assign resp_o   = resp_vld;
    assign rdata_bo = resp_vld ? resp_dat : '0;

endmodule
